// File: rtl/vga_filter_pkg.sv
// Shared definitions for the monochrome VGA filter.
// Holds display-mode encodings, BT.709 luma coefficients and the 2x2 Bayer
// ordered-dither matrix used by the per-channel dither/truncate stage.
package vga_filter_pkg;

  typedef enum logic [1:0] {
    MODE_COLOR = 2'd0,
    MODE_GREEN = 2'd1,
    MODE_AMBER = 2'd2,
    MODE_WHITE = 2'd3
  } mode_e;

  // BT.709 weights scaled so they sum to 2^LUMA_SHIFT.
  localparam int unsigned LUMA_R     = 54;
  localparam int unsigned LUMA_G     = 183;
  localparam int unsigned LUMA_B     = 19;
  localparam int unsigned LUMA_SHIFT = 8;

  // Bayer 2x2 = [[0,2],[3,1]], packed 2 bits per entry at index {y,x}.
  localparam logic [7:0] BAYER_2X2 = 8'b01_11_10_00;

  // Dither threshold for a pixel at line parity y, pixel parity x.
  function automatic logic [1:0] bayer_at(input logic y_par, input logic x_par);
    logic [7:0] tbl;
    tbl = BAYER_2X2;
    return tbl[{y_par, x_par, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/vga_dither_trunc.sv
// One colour channel of the output stage: reduces IN_W bits to OUT_W bits,
// either by ordered dither with saturation or by plain MSB truncation.
// Ports:
//   clk_vga, rst  pixel clock, synchronous active-high reset
//   v_i           channel value (IN_W bits)
//   x_par_i       pixel parity within the line
//   y_par_i       line parity within the frame
//   en_i          display enable; output forced to 0 when low
//   out_o         registered reduced value (OUT_W bits)
module vga_dither_trunc #(
  parameter int unsigned IN_W      = 6,
  parameter int unsigned OUT_W     = 3,
  parameter bit          DITHER_EN = 1'b1
) (
  input  logic             clk_vga,
  input  logic             rst,
  input  logic [IN_W-1:0]  v_i,
  input  logic             x_par_i,
  input  logic             y_par_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] out_o
);
  import vga_filter_pkg::*;

  localparam int unsigned D = IN_W - OUT_W;

  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;

  generate
    if (DITHER_EN && (D >= 2)) begin : g_dither
      // Threshold is scaled so the four phases span one output LSB evenly.
      localparam int unsigned   SH  = D - 2;
      localparam logic [IN_W:0] SAT = (IN_W+1)'((1 << IN_W) - 1);

      logic [IN_W:0]   sum;
      logic [IN_W-1:0] sat_v;

      always_comb begin
        sum   = {1'b0, v_i} + ((IN_W+1)'(bayer_at(y_par_i, x_par_i)) << SH);
        sat_v = (sum > SAT) ? SAT[IN_W-1:0] : sum[IN_W-1:0];
        out_d = OUT_W'(sat_v >> D);
      end
    end else begin : g_trunc
      logic unused_par;
      assign unused_par = ^{x_par_i, y_par_i};

      always_comb begin
        out_d = OUT_W'(v_i >> D);
      end
    end
  endgenerate

  // Output register with blanking.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= en_i ? out_d : '0;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/vga_mono_filter.sv
// Three-stage VGA output filter: BT.709 luma, colour/green/amber/white
// display modes latched at frame start, and ordered dither or truncation
// down to the DAC width. All outputs are registered with 3-cycle latency.
// Ports:
//   clk_vga, rst              pixel clock, synchronous active-high reset
//   r_in, g_in, b_in          input pixel (IN_W bits each)
//   de_in, hsync_in, vsync_in input display enable and syncs
//   mode_in                   requested mode (sampled on vsync leading edge)
//   r_out, g_out, b_out       DAC pixel (OUT_W bits each)
//   de_out, hsync_out, vsync_out  controls delayed with the pixel
//   mode_active               mode currently applied
module vga_mono_filter #(
  parameter int unsigned IN_W            = 6,
  parameter int unsigned OUT_W           = 3,
  parameter bit          DITHER_EN       = 1'b1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk_vga,
  input  logic             rst,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [1:0]       mode_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [1:0]       mode_active
);
  import vga_filter_pkg::*;

  localparam int unsigned     SUM_W     = IN_W + LUMA_SHIFT;
  localparam logic            SYNC_IDLE = SYNC_ACTIVE_LOW;
  localparam logic [IN_W-1:0] PIX_MAX   = '1;

  // ---------------------------------------------------------------- mode latch
  logic  vs_prev_q;
  mode_e mode_act_q, mode_act_d;
  logic  vs_act_in, vs_prev_act;

  assign vs_act_in   = vsync_in ^ SYNC_IDLE;
  assign vs_prev_act = vs_prev_q ^ SYNC_IDLE;

  // Load the requested mode only on the inactive->active vsync transition.
  always_comb begin
    mode_act_d = mode_act_q;
    if (vs_act_in && !vs_prev_act) begin
      mode_act_d = mode_e'(mode_in);
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_prev_q  <= SYNC_IDLE;
      mode_act_q <= MODE_COLOR;
    end else begin
      vs_prev_q  <= vsync_in;
      mode_act_q <= mode_act_d;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [IN_W-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic            s1_de_q, s1_hs_q, s1_vs_q;
  mode_e           s1_mode_q;

  // Mode travels with the pixel so a frame never mixes modes.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      s1_de_q   <= 1'b0;
      s1_hs_q   <= SYNC_IDLE;
      s1_vs_q   <= SYNC_IDLE;
      s1_mode_q <= MODE_COLOR;
    end else begin
      s1_r_q    <= r_in;
      s1_g_q    <= g_in;
      s1_b_q    <= b_in;
      s1_de_q   <= de_in;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      s1_mode_q <= mode_act_q;
    end
  end

  // Luma products and sum; Y is clamped defensively to full scale.
  logic [SUM_W-1:0] prod_r, prod_g, prod_b, luma_sum, luma_hi;
  logic [IN_W-1:0]  luma;

  always_comb begin
    prod_r   = SUM_W'(LUMA_R) * SUM_W'(s1_r_q);
    prod_g   = SUM_W'(LUMA_G) * SUM_W'(s1_g_q);
    prod_b   = SUM_W'(LUMA_B) * SUM_W'(s1_b_q);
    luma_sum = prod_r + prod_g + prod_b;
    luma_hi  = luma_sum >> LUMA_SHIFT;
    luma     = (luma_hi > SUM_W'(PIX_MAX)) ? PIX_MAX : luma_hi[IN_W-1:0];
  end

  // ---------------------------------------------------------------- stage 2
  logic [IN_W-1:0] s2_r_q, s2_g_q, s2_b_q;
  logic [IN_W-1:0] s2_r_d, s2_g_d, s2_b_d;
  logic            s2_de_q, s2_hs_q, s2_vs_q;
  logic            s2_x_q, s2_y_q;
  logic            x_cnt_q, x_cnt_d;
  logic            y_par_q, y_par_d;
  logic            s1_vs_act;

  assign s1_vs_act = s1_vs_q ^ SYNC_IDLE;

  // Mode remap.
  always_comb begin
    s2_r_d = s1_r_q;
    s2_g_d = s1_g_q;
    s2_b_d = s1_b_q;
    case (s1_mode_q)
      MODE_GREEN: begin
        s2_r_d = '0;
        s2_g_d = luma;
        s2_b_d = '0;
      end
      MODE_AMBER: begin
        s2_r_d = luma;
        s2_g_d = luma >> 1;
        s2_b_d = '0;
      end
      MODE_WHITE: begin
        s2_r_d = luma;
        s2_g_d = luma;
        s2_b_d = luma;
      end
      default: begin
        s2_r_d = s1_r_q;
        s2_g_d = s1_g_q;
        s2_b_d = s1_b_q;
      end
    endcase
  end

  // Pixel/line parity; s2_de_q is the previous S1 de, giving the falling edge.
  always_comb begin
    x_cnt_d = s1_de_q ? ~x_cnt_q : 1'b0;
    y_par_d = y_par_q;
    if (s1_vs_act) begin
      y_par_d = 1'b0;
    end else if (s2_de_q && !s1_de_q) begin
      y_par_d = ~y_par_q;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s2_r_q  <= '0;
      s2_g_q  <= '0;
      s2_b_q  <= '0;
      s2_de_q <= 1'b0;
      s2_hs_q <= SYNC_IDLE;
      s2_vs_q <= SYNC_IDLE;
      s2_x_q  <= 1'b0;
      s2_y_q  <= 1'b0;
      x_cnt_q <= 1'b0;
      y_par_q <= 1'b0;
    end else begin
      s2_r_q  <= s2_r_d;
      s2_g_q  <= s2_g_d;
      s2_b_q  <= s2_b_d;
      s2_de_q <= s1_de_q;
      s2_hs_q <= s1_hs_q;
      s2_vs_q <= s1_vs_q;
      s2_x_q  <= x_cnt_q;
      s2_y_q  <= y_par_q;
      x_cnt_q <= x_cnt_d;
      y_par_q <= y_par_d;
    end
  end

  // ---------------------------------------------------------------- stage 3
  vga_dither_trunc #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_EN(DITHER_EN)) u_dt_r (
    .clk_vga (clk_vga),
    .rst     (rst),
    .v_i     (s2_r_q),
    .x_par_i (s2_x_q),
    .y_par_i (s2_y_q),
    .en_i    (s2_de_q),
    .out_o   (r_out)
  );

  vga_dither_trunc #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_EN(DITHER_EN)) u_dt_g (
    .clk_vga (clk_vga),
    .rst     (rst),
    .v_i     (s2_g_q),
    .x_par_i (s2_x_q),
    .y_par_i (s2_y_q),
    .en_i    (s2_de_q),
    .out_o   (g_out)
  );

  vga_dither_trunc #(.IN_W(IN_W), .OUT_W(OUT_W), .DITHER_EN(DITHER_EN)) u_dt_b (
    .clk_vga (clk_vga),
    .rst     (rst),
    .v_i     (s2_b_q),
    .x_par_i (s2_x_q),
    .y_par_i (s2_y_q),
    .en_i    (s2_de_q),
    .out_o   (b_out)
  );

  logic s3_de_q, s3_hs_q, s3_vs_q;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s3_de_q <= 1'b0;
      s3_hs_q <= SYNC_IDLE;
      s3_vs_q <= SYNC_IDLE;
    end else begin
      s3_de_q <= s2_de_q;
      s3_hs_q <= s2_hs_q;
      s3_vs_q <= s2_vs_q;
    end
  end

  assign de_out      = s3_de_q;
  assign hsync_out   = s3_hs_q;
  assign vsync_out   = s3_vs_q;
  assign mode_active = mode_act_q;

endmodule

// File: tb/tb_vga_mono_filter.sv
// Directed self-checking bench for vga_mono_filter (IN_W=6, OUT_W=3).
// Two instances share the stimulus: one with dither disabled, one enabled.
module tb_vga_mono_filter;

  logic       clk_vga = 1'b0;
  logic       rst;
  logic [5:0] r, g, b;
  logic       de, hs, vs;
  logic [1:0] mode;

  logic [2:0] nr, ng, nb, dr, dg, db;
  logic       nde, nhs, nvs, dde, dhs, dvs;
  logic [1:0] nmode, dmode;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_vga = ~clk_vga;

  vga_mono_filter #(.IN_W(6), .OUT_W(3), .DITHER_EN(1'b0), .SYNC_ACTIVE_LOW(1'b1)) u_nd (
    .clk_vga(clk_vga), .rst(rst), .r_in(r), .g_in(g), .b_in(b),
    .de_in(de), .hsync_in(hs), .vsync_in(vs), .mode_in(mode),
    .r_out(nr), .g_out(ng), .b_out(nb), .de_out(nde),
    .hsync_out(nhs), .vsync_out(nvs), .mode_active(nmode)
  );

  vga_mono_filter #(.IN_W(6), .OUT_W(3), .DITHER_EN(1'b1), .SYNC_ACTIVE_LOW(1'b1)) u_d (
    .clk_vga(clk_vga), .rst(rst), .r_in(r), .g_in(g), .b_in(b),
    .de_in(de), .hsync_in(hs), .vsync_in(vs), .mode_in(mode),
    .r_out(dr), .g_out(dg), .b_out(db), .de_out(dde),
    .hsync_out(dhs), .vsync_out(dvs), .mode_active(dmode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk_vga);
    #1;
  endtask

  task automatic drive(input logic [5:0] rv, input logic [5:0] gv, input logic [5:0] bv,
                       input logic dv, input logic hv, input logic vv, input logic [1:0] mv);
    r = rv; g = gv; b = bv; de = dv; hs = hv; vs = vv; mode = mv;
  endtask

  // Stimulus/expectation tables.
  logic hs_pat [12] = '{1,0,0,1,1,1,1,1,1,1,1,1};
  logic vs_pat [12] = '{1,1,1,1,0,0,0,1,1,1,1,1};
  logic [5:0] w_r [6] = '{63, 0,  0, 63, 0, 0};
  logic [5:0] w_g [6] = '{ 0, 63, 0, 63, 0, 0};
  logic [5:0] w_b [6] = '{ 0, 0, 63, 63, 0, 0};
  logic       w_de[6] = '{1, 1, 1, 1, 0, 0};
  int         w_y [6] = '{1, 5, 0, 7, 0, 0};
  logic       d_de[12] = '{1,1,1,1,0,0,1,1,1,1,0,0};
  int         d_e4[12] = '{0,1,0,1,0,0,1,0,1,0,0,0};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    tick; tick;
    rst = 1'b0;

    // Colour mode; a mid-frame mode request must be ignored.
    drive(6'd40, 6'd20, 6'd8, 1'b1, 1'b1, 1'b1, 2'd3);
    tick; tick; tick;
    chk("color_r", nr, 5);
    chk("color_g", ng, 2);
    chk("color_b", nb, 1);
    chk("midframe_mode", nmode, 0);

    // Sync pulses, blanking, and a mode change on the vsync edge cycle.
    for (int i = 0; i < 14; i++) begin
      if (i < 12) drive(6'd20, 6'd20, 6'd20, 1'b0, hs_pat[i], vs_pat[i],
                        (i < 4) ? 2'd1 : ((i == 4) ? 2'd2 : 2'd0));
      tick;
      if (i == 3) chk("mode_before_edge", nmode, 0);
      if (i == 4) chk("mode_edge_load", nmode, 2);
      if (i >= 2) begin
        chk($sformatf("hs_%0d", i), nhs, hs_pat[i-2]);
        chk($sformatf("vs_%0d", i), nvs, vs_pat[i-2]);
        chk($sformatf("blank_r_%0d", i), nr, 0);
      end
    end
    chk("mode_after_vs", nmode, 2);

    // Amber mode.
    drive(6'd63, 6'd63, 6'd63, 1'b1, 1'b1, 1'b1, 2'd0);
    tick; tick; tick;
    chk("amber_r", nr, 7);
    chk("amber_g", ng, 3);
    chk("amber_b", nb, 0);

    // New frame in white mode.
    drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 2'd3);
    tick;
    chk("mode_white", nmode, 3);
    vs = 1'b1;
    tick;

    // Back-to-back luma pixels; each must appear exactly 3 cycles later.
    for (int i = 0; i < 6; i++) begin
      drive(w_r[i], w_g[i], w_b[i], w_de[i], 1'b1, 1'b1, 2'd3);
      tick;
      if (i == 1) chk("lat_not_early", nde, 0);
      if (i >= 2) begin
        chk($sformatf("white_r_%0d", i-2), nr, w_y[i-2]);
        chk($sformatf("white_g_%0d", i-2), ng, w_y[i-2]);
        chk($sformatf("white_b_%0d", i-2), nb, w_y[i-2]);
        chk($sformatf("white_de_%0d", i-2), nde, w_de[i-2]);
      end
    end

    // New frame in colour mode for the dither checks.
    drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick; tick;
    chk("mode_color_d", dmode, 0);
    vs = 1'b1;
    tick;

    // Two lines of constant red: R=4 shows the Bayer phases, R=63 saturates.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 14; i++) begin
        if (i < 12) drive((p == 0) ? 6'd4 : 6'd63, 6'd0, 6'd0, d_de[i], 1'b1, 1'b1, 2'd0);
        else        drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 2'd0);
        tick;
        if (i >= 2) begin
          chk($sformatf("dith%0d_r_%0d", p, i-2), dr,
              (p == 0) ? d_e4[i-2] : (d_de[i-2] ? 7 : 0));
          chk($sformatf("dith%0d_de_%0d", p, i-2), dde, d_de[i-2]);
        end
      end
    end

    // Mid-line reset with live pipeline contents and active syncs.
    drive(6'd63, 6'd63, 6'd63, 1'b1, 1'b0, 1'b0, 2'd3);
    tick; tick; tick;
    chk("pre_rst_r", nr, 7);
    chk("pre_rst_mode", nmode, 3);
    rst = 1'b1;
    tick;
    chk("rst_r", nr, 0);
    chk("rst_g", ng, 0);
    chk("rst_b", nb, 0);
    chk("rst_de", nde, 0);
    chk("rst_hs", nhs, 1);
    chk("rst_vs", nvs, 1);
    chk("rst_mode", nmode, 0);
    rst = 1'b0;
    drive(6'd40, 6'd20, 6'd8, 1'b1, 1'b1, 1'b1, 2'd0);
    tick; tick;
    chk("post_rst_de_early", nde, 0);
    tick;
    chk("post_rst_de", nde, 1);
    chk("post_rst_r", nr, 5);
    chk("post_rst_mode", nmode, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_mono_filter.md
Name: vga_mono_filter

Overview:
- Pipelined, parametrised successor to the top-level combinational monochrome remap on the VGA output path.
- Sits between the system video outputs (r/g/b, hsync, vsync, display-enable) and the board DAC pins.
- Computes BT.709 luma arithmetically and applies colour, green, amber or white display modes.
- Mode changes take effect only at frame boundaries; optional 2x2 ordered dither replaces plain MSB truncation.

Parameters:
- IN_W, 6, input bits per channel (4..8).
- OUT_W, 3, output bits per channel (1..IN_W).
- DITHER_EN, 1, enables ordered dither; it only has effect when IN_W-OUT_W >= 2.
- SYNC_ACTIVE_LOW, 1, polarity of hsync_in/vsync_in, and the same polarity on the outputs.

Ports:
- clk_vga  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- r_in, g_in, b_in  in  IN_W each  pixel colour.
- de_in  in  1  display enable (active video).
- hsync_in, vsync_in  in  1 each  syncs.
- mode_in  in  2  requested mode: 0 colour, 1 green, 2 amber, 3 white.
- r_out, g_out, b_out  out  OUT_W each  to DAC.
- de_out, hsync_out, vsync_out  out  1 each  delayed controls.
- mode_active  out  2  mode currently applied.

Behaviour:
- Clocking and reset:
  - Single clock domain (clk_vga); rst is synchronous and active-high.
  - Reset clears all pipeline registers.
  - Reset output values: rgb 0, de_out 0, syncs at their inactive level, mode_active 0.
- Latency: exactly 3 cycles from input to output for every output (rgb, de, hsync, vsync); controls are delayed in lockstep with the pixel data.
- S1: register inputs; compute products 54*R, 183*G, 19*B (coefficients sum to 256).
- S2: Y = (sum) >> 8, width IN_W; clamp to 2^IN_W-1 (defensive). Mode map:
  - 0: pass R, G, B.
  - 1: (0, Y, 0).
  - 2: (Y, Y>>1, 0).
  - 3: (Y, Y, Y).
- S3: per-channel dither/truncate, with D = IN_W-OUT_W.
  - Dither active (DITHER_EN=1 and D >= 2): out = sat(v + (B[y][x] << (D-2))) >> D.
    - Bayer matrix B = [[0,2],[3,1]], indexed by y = line parity, x = pixel parity.
    - Saturation limit: 2^IN_W-1.
  - Otherwise: out = v[IN_W-1:D].
- Blanking: when S3's de is 0, rgb outputs are 0 regardless of input values.
- Position tracking, taken at S2 alignment:
  - x parity: cleared while de=0; toggles on each cycle with de=1.
  - y parity: toggles on each de falling edge; cleared while vsync is active.
- Mode latch:
  - mode_active loads mode_in on the cycle vsync_in transitions inactive->active (edge detected against the previous input sample).
  - mode_in changes at any other time are ignored.
  - Simultaneous vsync edge and mode change: the value present on the edge cycle is loaded.
  - Reset mid-frame: colour mode until the next vsync edge.
- Pipeline alignment of mode: the mode used in S2 is mode_active registered alongside the S1 data, so no pixel inside a frame mixes modes.
- Arithmetic width: product sum needs IN_W+8 bits; the dither add needs IN_W+1 bits before saturation.

Decomposition:
- Shared package vga_filter_pkg holds:
  - Mode constants (MODE_COLOR=0, MODE_GREEN=1, MODE_AMBER=2, MODE_WHITE=3).
  - Luma coefficients (54, 183, 19, shift 8).
  - The 2x2 Bayer constant.
- Sub-module vga_dither_trunc: one channel, parameters IN_W/OUT_W/DITHER_EN, inputs v, x parity, y parity; registered output. Instantiated three times in S3.

Test Plan (IN_W=6, OUT_W=3):
- Luma, white mode, DITHER_EN=0, de=1:
  - (63,0,0) -> Y=13 -> out 1,1,1.
  - (0,63,0) -> Y=45 -> 5,5,5.
  - (0,0,63) -> Y=4 -> 0,0,0.
  - (63,63,63) -> 7,7,7.
  - Every output appears exactly 3 cycles after its input.
- Amber mode, input (63,63,63), dither off -> r=7, g=3, b=0. Colour mode, input (40,20,8) -> 5,2,1.
- Dither on, colour mode, constant R=4, D=3 (offsets 0,4,6,2):
  - Line 0 -> r alternates 0,1,0,1.
  - Line 1 -> 1,0,1,0.
  - Input R=63 saturates to 7 on all four phases.
- Mode latch:
  - Change mode_in 0->3 mid-frame -> outputs stay colour until the vsync falling edge (SYNC_ACTIVE_LOW), then mode_active=3.
  - Mode change on the exact edge cycle -> the new value is taken.
- Blanking and sync:
  - de_in=0 with nonzero rgb -> rgb_out=0.
  - hsync/vsync pulses reproduced with their widths unchanged and a 3-cycle delay.
- Reset: assert rst mid-line with nonzero pipeline contents -> next cycle rgb=0, de_out=0, syncs inactive (high), mode_active=0; after release, first valid pixel appears 3 cycles after input.
